// File: rtl/div_by_3_arb.sv
// rtl/div_by_3_arb.sv - round-robin sequencer sharing one div_by_3 engine among requesters
module div_by_3_arb #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [16*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]      req_rdy,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_y,
  output logic                  eng_pass,
  output logic [15:0]           eng_x,
  input  logic                  eng_busy,
  input  logic                  eng_valid,
  input  logic [15:0]           eng_y,
  output logic                  err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] gnt_next_ptr;
  logic [ID_W-1:0] cand;
  logic            gnt_found;
  logic            grant;
  logic [WD_W-1:0] wdog;
  logic            wd_hit;

  // Round-robin search: first requester with valid, starting at rr_ptr and wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!gnt_found && req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A grant needs the engine idle; gating with rst_n keeps outputs quiet while reset is held,
  // and eng_busy covers an engine still finishing work started before a controller-only reset.
  assign grant        = rst_n && (state == IDLE) && gnt_found && !eng_busy;
  assign gnt_next_ptr = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  // The watchdog counts RUN cycles from zero; the last permitted cycle is TIMEOUT-1.
  assign wd_hit       = (wdog == WD_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an engine result always wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (eng_valid) begin
          state_nxt = RESP;
        end else if (wd_hit) begin
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational handshake outputs: accept and engine start happen together in the grant cycle.
  always_comb begin
    req_rdy  = '0;
    eng_pass = 1'b0;
    eng_x    = '0;
    if (grant) begin
      req_rdy  = N_REQ'(1) << gnt_idx;
      eng_pass = 1'b1;
      eng_x    = req_x[16*gnt_idx +: 16];
    end
  end

  // Datapath registers: pointer, owner, watchdog, response holding and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      owner       <= '0;
      wdog        <= '0;
      rsp_vld     <= 1'b0;
      rsp_id      <= '0;
      rsp_y       <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner  <= gnt_idx;
            rr_ptr <= gnt_next_ptr;
            wdog   <= '0;
          end
        end
        RUN: begin
          if (eng_valid) begin
            rsp_y   <= eng_y;
            rsp_id  <= owner;
            rsp_vld <= 1'b1;
          end else if (wd_hit) begin
            err_timeout <= 1'b1;
          end else if (wdog != {WD_W{1'b1}}) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
          end
        end
        default: begin
          rsp_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_by_3_arb.sv
// tb/tb_div_by_3_arb.sv - scoreboard bench for div_by_3_arb with a behavioural engine and requesters
module tb_div_by_3_arb;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_vld;
  logic [16*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic                rsp_vld;
  logic                rsp_rdy;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_y;
  logic                eng_pass;
  logic [15:0]         eng_x;
  logic                eng_busy;
  logic                eng_valid;
  logic [15:0]         eng_y;
  logic                err_timeout;

  typedef struct {
    int id;
    int y;
  } exp_t;

  exp_t        exp_q[$];
  int          got_ids[$];
  int          got_ys[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic [15:0] src_mem[N_REQ][64];
  int          src_wr[N_REQ];
  int          src_rd[N_REQ];
  bit          hs[N_REQ];
  bit          src_en = 1'b1;

  int          eng_lat = 3;
  bit          eng_hang = 1'b0;
  int          hang_len = 25;
  bit          rdy_rand = 1'b0;
  bit          rdy_hold = 1'b0;
  int          pass_cyc = 0;
  int          pass_lat = 0;
  int          mptr = 0;

  logic [15:0] e_x;
  bit          e_start = 1'b0;
  bit          e_run = 1'b0;
  bit          e_hang = 1'b0;
  int          e_age = 0;
  int          e_lat = 1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div_by_3_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_x      (req_x),
    .req_rdy    (req_rdy),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .eng_pass   (eng_pass),
    .eng_x      (eng_x),
    .eng_busy   (eng_busy),
    .eng_valid  (eng_valid),
    .eng_y      (eng_y),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int i, input logic [15:0] x);
    src_mem[i][src_wr[i] % 64] = x;
    src_wr[i]++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_rd[i] != src_wr[i]) return 1'b0;
    end
    return (req_vld == '0);
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(drained() && exp_q.size() == 0 && !rsp_vld && !eng_busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_done"}, (n < budget), 1);
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    exp_q.delete();
    got_ids.delete();
    got_ys.delete();
    rst_n = 1'b1;
    tick(2);
  endtask

  // Requesters: each presents its queued operands in order and holds valid until accepted.
  initial begin
    req_vld = '0;
    req_x   = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i]) begin
          hs[i]      = 1'b0;
          req_vld[i] = 1'b0;
          src_rd[i]++;
        end
        if (!req_vld[i] && src_en && src_rd[i] != src_wr[i]) begin
          req_vld[i]          = 1'b1;
          req_x[16*i +: 16]   = src_mem[i][src_rd[i] % 64];
        end
      end
    end
  end

  // Consumer ready: always, held low, or random.
  initial begin
    rsp_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_rdy = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1);
    end
  end

  // Engine model: busy after a pass, result pulse e_lat cycles after the pass, independent of DUT reset.
  initial begin
    eng_busy  = 1'b0;
    eng_valid = 1'b0;
    eng_y     = '0;
    forever begin
      @(negedge clk);
      if (eng_pass) begin
        e_start = 1'b1;
        e_x     = eng_x;
      end
      @(posedge clk);
      #1;
      eng_valid = 1'b0;
      if (e_run) e_age++;
      if (e_start) begin
        e_start  = 1'b0;
        e_run    = 1'b1;
        e_age    = 1;
        e_lat    = eng_lat;
        e_hang   = eng_hang;
        eng_busy = 1'b1;
      end
      if (e_run) begin
        if (!e_hang && e_age == e_lat) begin
          eng_valid = 1'b1;
          eng_y     = e_x / 16'd3;
        end
        if (e_age > (e_hang ? hang_len : e_lat)) begin
          eng_busy = 1'b0;
          e_run    = 1'b0;
        end
      end
    end
  end

  // Grant monitor: round-robin reference, one-hot accept, and scoreboard push of floor(x/3).
  initial begin
    int g;
    int c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mptr = 0;
      end else if (req_rdy != '0 || eng_pass) begin
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
          c = (mptr + k) % N_REQ;
          if (g < 0 && req_vld[c]) g = c;
        end
        chk("grant_pass", eng_pass, 1);
        chk("grant_onehot", req_rdy, (g < 0) ? 0 : (1 << g));
        chk("grant_not_busy", eng_busy, 0);
        chk("grant_not_resp", rsp_vld, 0);
        for (int i = 0; i < N_REQ; i++) begin
          if (req_vld[i] && req_rdy[i]) hs[i] = 1'b1;
        end
        if (g >= 0) begin
          chk("eng_x", eng_x, req_x[16*g +: 16]);
          if (!eng_hang) exp_q.push_back('{id: g, y: int'(req_x[16*g +: 16]) / 3});
          mptr = (g + 1) % N_REQ;
        end
        pass_cyc = cyc;
        pass_lat = eng_lat;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks holding, latency and timeout timing.
  initial begin
    bit          pv;
    bit          pacc;
    bit          perr;
    logic [ID_W-1:0] pid;
    logic [15:0] py;
    exp_t        e;
    pv = 1'b0; pacc = 1'b0; perr = 1'b0; pid = '0; py = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv   = 1'b0;
        pacc = 1'b0;
        perr = 1'b0;
      end else begin
        if (rsp_vld && pv && !pacc) begin
          chk("rsp_id_stable", rsp_id, pid);
          chk("rsp_y_stable", rsp_y, py);
        end
        if (rsp_vld && !pv) chk("rsp_latency", cyc - pass_cyc, pass_lat + 1);
        if (rsp_vld && rsp_rdy) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_y", rsp_y, e.y);
          end
          got_ids.push_back(int'(rsp_id));
          got_ys.push_back(int'(rsp_y));
        end
        if (err_timeout && !perr) chk("timeout_cycle", cyc - pass_cyc, TIMEOUT + 1);
        pv   = rsp_vld;
        pacc = rsp_vld && rsp_rdy;
        pid  = rsp_id;
        py   = rsp_y;
        perr = err_timeout;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench stopped by global time limit");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    push(0, 16'd300);
    tick(3);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_eng_pass", eng_pass, 0);
    chk("rst_eng_x", eng_x, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;

    wait_done("single", 100);
    chk("single_count", got_ids.size(), 1);
    if (got_ids.size() >= 1) begin
      chk("single_id", got_ids[0], 0);
      chk("single_y", got_ys[0], 100);
    end

    do_reset();
    src_en = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_REQ; i++) push(i, 16'(3 * (i + 1)));
    tick(1);
    src_en = 1'b1;
    wait_done("rr", 400);
    chk("rr_count", got_ids.size(), 8);
    for (int k = 0; k < got_ids.size(); k++) begin
      chk("rr_id", got_ids[k], k % N_REQ);
      chk("rr_y", got_ys[k], (k % N_REQ) + 1);
    end

    rdy_hold = 1'b1;
    push(1, 16'd999);
    n = 0;
    while (!rsp_vld && n < 50) begin tick(1); n++; end
    chk("bp_rsp_seen", (n < 50), 1);
    push(2, 16'd1234);
    tick(20);
    chk("bp_vld_held", rsp_vld, 1);
    chk("bp_id", rsp_id, 1);
    chk("bp_y", rsp_y, 333);
    chk("bp_req2_waiting", req_vld[2], 1);
    rdy_hold = 1'b0;
    wait_done("bp", 200);

    eng_hang = 1'b1;
    n = got_ids.size();
    push(0, 16'd42);
    begin
      int w;
      w = 0;
      while (!err_timeout && w < 60) begin tick(1); w++; end
      chk("to_err_set", err_timeout, 1);
      w = 0;
      while (eng_busy && w < 60) begin tick(1); w++; end
      chk("to_busy_drop", (w < 60), 1);
    end
    chk("to_no_rsp", got_ids.size(), n);
    eng_hang = 1'b0;
    push(3, 16'd7);
    wait_done("to_after", 100);
    chk("to_sticky", err_timeout, 1);

    eng_lat = 8;
    push(1, 16'd500);
    n = 0;
    while (!(req_vld == '0 && eng_busy) && n < 50) begin tick(1); n++; end
    chk("mr_started", (n < 50), 1);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mr_req_rdy", req_rdy, 0);
    chk("mr_eng_pass", eng_pass, 0);
    chk("mr_rsp_vld", rsp_vld, 0);
    chk("mr_rsp_id", rsp_id, 0);
    chk("mr_rsp_y", rsp_y, 0);
    chk("mr_err", err_timeout, 0);
    tick(2);
    exp_q.delete();
    got_ids.delete();
    got_ys.delete();
    rst_n = 1'b1;
    push(2, 16'd600);
    wait_done("mr", 200);
    chk("mr_count", got_ids.size(), 1);
    if (got_ids.size() >= 1) chk("mr_y", got_ys[0], 200);
    eng_lat = 3;

    do_reset();
    push(3, 16'd0);
    wait_done("bnd0", 100);
    push(0, 16'd65535);
    wait_done("bnd1", 100);
    chk("bnd_count", got_ids.size(), 2);
    if (got_ids.size() >= 2) begin
      chk("wrap_id0", got_ids[0], 3);
      chk("wrap_id1", got_ids[1], 0);
      chk("bnd_y0", got_ys[0], 0);
      chk("bnd_y1", got_ys[1], 21845);
    end

    rdy_rand = 1'b1;
    for (int t = 0; t < 300; t++) begin
      int i;
      tick($urandom_range(0, 3));
      eng_lat = $urandom_range(1, 6);
      i = $urandom_range(0, N_REQ - 1);
      if (src_wr[i] - src_rd[i] < 60) push(i, 16'($urandom));
    end
    wait_done("rand", 8000);
    rdy_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
